// File: rtl/trg_src_sched.sv
// Run-control FSM and trigger-source scheduler: conditions coincidence, external and
// periodic sources, gates them by run state and mask, and keeps trigger ID / miss stats.
//
// state | meaning
// IDLE  | no run; sources gated off, trigger enable low
// ARM   | one clock; clears ID, miss count, last source and period counter
// RUN   | sources live, trigger enable high
// DRAIN | DRAIN_CYCLES clocks with sources off; accepts still counted
module trg_src_sched #(
    parameter int CYC_W        = 24,
    parameter int ID_W         = 16,
    parameter int DRAIN_CYCLES = 256
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run_start_in,
    input  logic             run_stop_in,
    input  logic [2:0]       src_mask_in,
    input  logic [CYC_W-1:0] cyc_period_in,
    input  logic             coincid_raw_in,
    input  logic             ext_trg_in,
    input  logic             eff_trg_in,
    output logic             coincid_trg_out,
    output logic             ext_trg_syn_out,
    output logic             cycled_trg_out,
    output logic             trg_enb_out,
    output logic [ID_W-1:0]  eff_trg_cnt_out,
    output logic [1:0]       last_src_out,
    output logic [ID_W-1:0]  missed_cnt_out,
    output logic             run_active_out
);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic             coin_q;
    logic             ext_s1;
    logic             ext_s2;
    logic             ext_q;
    logic [CYC_W-1:0] cyc_cnt;
    logic [DRN_W-1:0] drn_cnt;
    logic             src_evt;
    logic [1:0]       pend_code;

    logic             run_go;
    logic             cyc_on;
    logic             cyc_hit;
    logic             cyc_wrap;
    logic [CYC_W-1:0] period_m1;

    // Source outputs are registered, so gate on "still in RUN next clock" to keep
    // them silent for the whole of DRAIN.
    always_comb begin
        run_go    = (state == ST_RUN) && !run_stop_in;
        period_m1 = cyc_period_in - CYC_W'(1);
        cyc_on    = (state == ST_RUN) && (cyc_period_in != '0);
        cyc_hit   = cyc_on && (cyc_cnt == period_m1);
        cyc_wrap  = (cyc_cnt >= period_m1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            coin_q          <= 1'b0;
            ext_s1          <= 1'b0;
            ext_s2          <= 1'b0;
            ext_q           <= 1'b0;
            cyc_cnt         <= '0;
            drn_cnt         <= '0;
            src_evt         <= 1'b0;
            pend_code       <= 2'd0;
            coincid_trg_out <= 1'b0;
            ext_trg_syn_out <= 1'b0;
            cycled_trg_out  <= 1'b0;
            trg_enb_out     <= 1'b0;
            eff_trg_cnt_out <= '0;
            last_src_out    <= 2'd0;
            missed_cnt_out  <= '0;
            run_active_out  <= 1'b0;
        end else begin
            coin_q <= coincid_raw_in;
            ext_s1 <= ext_trg_in;
            ext_s2 <= ext_s1;
            ext_q  <= ext_s2;

            coincid_trg_out <= run_go & src_mask_in[0] & coincid_raw_in & ~coin_q;
            ext_trg_syn_out <= run_go & src_mask_in[1] & ext_s2 & ~ext_q;
            cycled_trg_out  <= run_go & src_mask_in[2] & cyc_hit;
            trg_enb_out     <= (state == ST_RUN);

            // Simultaneous sources collapse into one event with a priority code.
            src_evt <= coincid_trg_out | ext_trg_syn_out | cycled_trg_out;
            if (coincid_trg_out) begin
                pend_code <= 2'd1;
            end else if (ext_trg_syn_out) begin
                pend_code <= 2'd2;
            end else if (cycled_trg_out) begin
                pend_code <= 2'd3;
            end

            if (cyc_on) begin
                cyc_cnt <= cyc_wrap ? '0 : cyc_cnt + CYC_W'(1);
            end else begin
                cyc_cnt <= '0;
            end

            if (state == ST_ARM) begin
                eff_trg_cnt_out <= '0;
                missed_cnt_out  <= '0;
                last_src_out    <= 2'd0;
            end else begin
                if (eff_trg_in && (state == ST_RUN || state == ST_DRAIN)) begin
                    eff_trg_cnt_out <= eff_trg_cnt_out + ID_W'(1);
                    last_src_out    <= pend_code;
                end
                if (src_evt && !eff_trg_in && (missed_cnt_out != '1)) begin
                    missed_cnt_out <= missed_cnt_out + ID_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (run_start_in && !run_stop_in) begin
                        state          <= ST_ARM;
                        run_active_out <= 1'b1;
                    end
                end
                ST_ARM: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_stop_in) begin
                        state   <= ST_DRAIN;
                        drn_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt == DRN_W'(DRAIN_CYCLES - 1)) begin
                        state          <= ST_IDLE;
                        run_active_out <= 1'b0;
                        drn_cnt        <= '0;
                    end else begin
                        drn_cnt <= drn_cnt + DRN_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trg_src_sched.sv
// Randomized and directed bench for trg_src_sched, checked every clock against a
// behavioural model built from input histories and run-level bookkeeping.
module tb_trg_src_sched;
    localparam int CYC_W        = 24;
    localparam int ID_W         = 16;
    localparam int DRAIN_CYCLES = 256;
    localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [2:0]       mask = 3'b000;
    logic [CYC_W-1:0] period = '0;
    logic             raw = 1'b0;
    logic             ext = 1'b0;
    logic             eff = 1'b0;

    logic             coincid_trg;
    logic             ext_trg_syn;
    logic             cycled_trg;
    logic             trg_enb;
    logic [ID_W-1:0]  eff_trg_cnt;
    logic [1:0]       last_src;
    logic [ID_W-1:0]  missed_cnt;
    logic             run_active;

    trg_src_sched #(.CYC_W(CYC_W), .ID_W(ID_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .run_start_in    (start),
        .run_stop_in     (stop),
        .src_mask_in     (mask),
        .cyc_period_in   (period),
        .coincid_raw_in  (raw),
        .ext_trg_in      (ext),
        .eff_trg_in      (eff),
        .coincid_trg_out (coincid_trg),
        .ext_trg_syn_out (ext_trg_syn),
        .cycled_trg_out  (cycled_trg),
        .trg_enb_out     (trg_enb),
        .eff_trg_cnt_out (eff_trg_cnt),
        .last_src_out    (last_src),
        .missed_cnt_out  (missed_cnt),
        .run_active_out  (run_active)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: run state, remaining drain clocks, input histories, statistics
    int m_st = M_IDLE;
    int m_drain = 0;
    bit m_raw_prev = 1'b0;
    bit ext_hist[4];
    int m_cyc = 0;
    bit m_coin = 1'b0, m_ext = 1'b0, m_cyo = 1'b0;
    bit m_evt = 1'b0;
    int m_pend = 0;
    bit m_enb = 1'b0;
    int m_id = 0, m_last = 0, m_miss = 0;
    bit m_act = 1'b0;

    bit auto_ack = 1'b0;
    bit ack_next = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit go, hit, ext_rise, nc, ne, ny;
        int per;
        if (rst) begin
            m_st = M_IDLE; m_drain = 0; m_raw_prev = 0; m_cyc = 0;
            for (int k = 0; k < 4; k++) ext_hist[k] = 1'b0;
            m_coin = 0; m_ext = 0; m_cyo = 0; m_evt = 0; m_pend = 0; m_enb = 0;
            m_id = 0; m_last = 0; m_miss = 0; m_act = 0;
            return;
        end
        per = int'(period);
        for (int k = 3; k > 0; k--) ext_hist[k] = ext_hist[k-1];
        ext_hist[0] = ext;
        ext_rise = ext_hist[2] && !ext_hist[3];
        go  = (m_st == M_RUN) && !stop;
        hit = (m_st == M_RUN) && (per != 0) && (m_cyc == per - 1);
        nc  = go && mask[0] && raw && !m_raw_prev;
        ne  = go && mask[1] && ext_rise;
        ny  = go && mask[2] && hit;

        if (m_st == M_ARM) begin
            m_id = 0; m_miss = 0; m_last = 0;
        end else begin
            if (eff && (m_st == M_RUN || m_st == M_DRAIN)) begin
                m_id = (m_id + 1) % 65536;
                m_last = m_pend;
            end
            if (m_evt && !eff && m_miss < 65535) m_miss++;
        end

        m_evt = m_coin || m_ext || m_cyo;
        if (m_coin) m_pend = 1;
        else if (m_ext) m_pend = 2;
        else if (m_cyo) m_pend = 3;

        m_enb = (m_st == M_RUN);
        if (m_st == M_RUN && per != 0) m_cyc = (m_cyc + 1 >= per) ? 0 : m_cyc + 1;
        else m_cyc = 0;

        case (m_st)
            M_IDLE:  if (start && !stop) m_st = M_ARM;
            M_ARM:   m_st = M_RUN;
            M_RUN:   if (stop) begin m_st = M_DRAIN; m_drain = DRAIN_CYCLES; end
            default: begin
                m_drain--;
                if (m_drain == 0) m_st = M_IDLE;
            end
        endcase
        m_act = (m_st != M_IDLE);
        m_raw_prev = raw;
        m_coin = nc; m_ext = ne; m_cyo = ny;
    endtask

    task automatic compare_all();
        check("coincid_trg", 32'(coincid_trg), 32'(m_coin));
        check("ext_trg_syn", 32'(ext_trg_syn), 32'(m_ext));
        check("cycled_trg",  32'(cycled_trg),  32'(m_cyo));
        check("trg_enb",     32'(trg_enb),     32'(m_enb));
        check("eff_trg_cnt", 32'(eff_trg_cnt), m_id);
        check("last_src",    32'(last_src),    m_last);
        check("missed_cnt",  32'(missed_cnt),  m_miss);
        check("run_active",  32'(run_active),  32'(m_act));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (auto_ack) begin
            eff = ack_next;
            ack_next = m_coin || m_ext || m_cyo;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic set_ack(input bit on);
        auto_ack = on; ack_next = 1'b0; eff = 1'b0;
    endtask

    initial begin
        int cnt, base, n;
        #1;
        ticks(2);
        rst = 1'b0;
        tick();
        check("reset_id", 32'(eff_trg_cnt), 0);
        check("reset_active", 32'(run_active), 0);

        // cycled source, 5 periods of 1000 with acknowledges
        mask = 3'b100; period = CYC_W'(1000); set_ack(1);
        pulse_start();
        ticks(5010);
        check("t1_id", 32'(eff_trg_cnt), 5);
        check("t1_last", 32'(last_src), 3);
        check("t1_miss", 32'(missed_cnt), 0);

        // coincidence level held high gives one pulse per rising edge
        mask = 3'b001; cnt = 0;
        raw = 1'b1;
        for (int i = 0; i < 50; i++) begin tick(); cnt += int'(coincid_trg); end
        raw = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(coincid_trg); end
        raw = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(coincid_trg); end
        raw = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); cnt += int'(coincid_trg); end
        check("t2_coin_pulses", cnt, 2);

        // coincidence and external together: one event, coincidence wins
        mask = 3'b011; base = m_miss;
        ext = 1'b1; tick(); tick();
        raw = 1'b1; tick();
        check("t3_coin", 32'(coincid_trg), 1);
        check("t3_ext", 32'(ext_trg_syn), 1);
        ticks(4);
        check("t3_last", 32'(last_src), 1);
        check("t3_miss", 32'(missed_cnt), base);
        ext = 1'b0; raw = 1'b0; ticks(5);

        // external pulses with no accepts: one miss each, 3-clock latency
        mask = 3'b010; set_ack(0); base = m_miss;
        for (int p = 0; p < 4; p++) begin
            ext = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                tick();
                if (k == 3) check("t4_ext_lat", 32'(ext_trg_syn), 1);
            end
            ext = 1'b0;
            ticks(10);
        end
        check("t4_miss", 32'(missed_cnt), base + 4);

        // stop: enable drops, DRAIN lasts DRAIN_CYCLES clocks
        stop = 1'b1; tick(); stop = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            if (!run_active) break;
            if (k == 1) check("t6_enb_after_stop", 32'(trg_enb), 0);
            n++;
            tick();
        end
        check("t6_drain_len", n, DRAIN_CYCLES);

        // start and stop together in IDLE are ignored
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        ticks(3);
        check("t6_start_stop_idle", 32'(run_active), 0);

        // ID wrap after 65536 accepts
        mask = 3'b000; period = '0;
        pulse_start(); tick();
        eff = 1'b1;
        ticks(65535);
        check("t5_id_ffff", 32'(eff_trg_cnt), 32'hFFFF);
        tick();
        check("t5_id_wrap", 32'(eff_trg_cnt), 0);
        eff = 1'b0;

        // reset in the middle of a run
        mask = 3'b111; period = CYC_W'(3); set_ack(1);
        for (int i = 0; i < 50; i++) begin raw = ~raw; tick(); end
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_id", 32'(eff_trg_cnt), 0);
        check("t6_rst_active", 32'(run_active), 0);
        check("t6_rst_enb", 32'(trg_enb), 0);
        tick();

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            mask = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: period = '0;
                1: period = CYC_W'(1);
                2: period = CYC_W'(2);
                3: period = CYC_W'($urandom_range(3, 9));
                default: period = CYC_W'($urandom_range(10, 60));
            endcase
            set_ack(1'($urandom_range(0, 1)));
            pulse_start();
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 3) == 0) raw = ~raw;
                if ($urandom_range(0, 4) == 0) ext = ~ext;
                if (!auto_ack) eff = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 149) == 0) period = CYC_W'($urandom_range(0, int'(period)));
                if ($urandom_range(0, 99) == 0) mask = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 199) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (r % 4 == 3) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else begin
                stop = 1'b1; tick(); stop = 1'b0;
            end
            for (int i = 0; i < DRAIN_CYCLES + 10; i++) begin
                if ($urandom_range(0, 3) == 0) raw = ~raw;
                if ($urandom_range(0, 4) == 0) ext = ~ext;
                if (!auto_ack) eff = ($urandom_range(0, 7) == 0);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/trg_src_sched.md
Name: trg_src_sched

Overview:
Run-control and trigger-source scheduler that feeds the trigger output controller.
- Conditions the three trigger sources: coincidence edge-detect, external synchroniser plus edge-detect, and an internal periodic generator.
- Gates the sources per run state and per-source mask, and drives the trigger-enable input.
- Maintains the 16-bit effective trigger ID consumed by the trigger output controller.
- Records the source of the last accepted trigger and counts source events that were not accepted.
- Sits between slow-control registers and the trigger output controller, in the 50 MHz clock domain.

Parameters:
CYC_W, 24, width of the cycled-trigger period (clock cycles).
ID_W, 16, width of trigger ID and missed counters.
DRAIN_CYCLES, 256, clocks spent in DRAIN after a stop request.

Ports:
clk_in  in  1  system clock, 50 MHz
rst_in  in  1  synchronous reset, active-high
run_start_in  in  1  1-clock pulse, start run
run_stop_in  in  1  1-clock pulse, stop run
src_mask_in  in  3  source enable: bit0 coincidence, bit1 external, bit2 cycled
cyc_period_in  in  CYC_W  cycled trigger period in clocks; 0 = cycled source off
coincid_raw_in  in  1  coincidence level, synchronous to clk_in
ext_trg_in  in  1  external trigger, asynchronous
eff_trg_in  in  1  1-clock accepted-trigger pulse from trigger output controller
coincid_trg_out  out  1  1-clock coincidence pulse
ext_trg_syn_out  out  1  1-clock synchronised external pulse
cycled_trg_out  out  1  1-clock periodic pulse
trg_enb_out  out  1  trigger enable
eff_trg_cnt_out  out  ID_W  effective trigger ID
last_src_out  out  2  source of last accepted trigger: 0 none, 1 coincidence, 2 external, 3 cycled
missed_cnt_out  out  ID_W  source events not followed by eff_trg_in
run_active_out  out  1  high in ARM/RUN/DRAIN

Behaviour:
- Reset:
  - All outputs 0; state IDLE.
  - Synchroniser, edge registers, period counter, drain counter and pending-source register cleared.
- FSM states and transitions:
  - IDLE: trg_enb_out=0. run_start_in=1 and run_stop_in=0 -> ARM. Start and stop in the same cycle: stay IDLE.
  - ARM, one clock: clear eff_trg_cnt_out, missed_cnt_out, last_src_out and period counter -> RUN.
  - RUN: trg_enb_out=1. run_stop_in -> DRAIN. run_start_in is ignored.
  - DRAIN: trg_enb_out=0; all source outputs forced 0; drain counter runs 0..DRAIN_CYCLES-1, then -> IDLE. run_start_in and run_stop_in are ignored.
- Outputs are registered. trg_enb_out changes in the clock after the state transition.
- Coincidence:
  - Register coincid_raw_in.
  - coincid_trg_out=1 for exactly 1 clock on a rising edge, when state=RUN and src_mask_in[0]=1.
  - A level held high produces one pulse only.
- External:
  - 2-flop synchroniser, then rising-edge detect.
  - ext_trg_syn_out is a 1-clock pulse gated by RUN and src_mask_in[1].
  - Latency from ext_trg_in rising edge to pulse: 3 clocks.
- Cycled:
  - In RUN with cyc_period_in != 0, the period counter counts 0..cyc_period_in-1 and wraps.
  - On the clock the counter equals cyc_period_in-1, cycled_trg_out=1 if src_mask_in[2]=1.
  - The counter runs even while the source is masked, so phase is preserved.
  - cyc_period_in=0: counter held at 0, no pulses.
  - cyc_period_in=1: pulse every clock.
  - A new cyc_period_in smaller than the current count makes the counter wrap to 0 on the next clock with no pulse.
  - Outside RUN the counter is held at 0.
- Pending source:
  - Any source output asserted in a clock sets src_evt (registered 1 clock).
  - The pending code is chosen by priority coincidence > external > cycled when sources fire together.
- Accept and miss accounting:
  - eff_trg_in=1 in RUN or DRAIN: eff_trg_cnt_out += 1 (wraps 0xFFFF -> 0x0000) and last_src_out <= pending code.
  - eff_trg_in in IDLE is ignored.
  - src_evt=1 and eff_trg_in=0 in the following clock: missed_cnt_out += 1, saturating at 0xFFFF.
  - Simultaneous sources are one event, not multiple misses.
  - The first accepted trigger of a run yields ID 1.
- Reset mid-run: immediate return to IDLE with all outputs 0; no drain.

Test Plan:
1. Reset, start pulse, mask=3'b100, cyc_period_in=1000; emulate 1-clock eff_trg_in after each source pulse -> cycled_trg_out every 1000 clocks; after 5 pulses eff_trg_cnt_out=5, last_src_out=3, missed_cnt_out=0.
2. RUN, mask=3'b001; coincid_raw_in held high 50 clocks, then low, then high again -> exactly 2 coincid_trg_out pulses, each 1 clock wide.
3. RUN, mask=3'b011; coincidence edge and external pulse in the same clock -> both outputs pulse; after eff_trg_in, last_src_out=1 and missed_cnt_out unchanged.
4. RUN, mask=3'b010; ext_trg_in pulses with eff_trg_in held 0 -> missed_cnt_out increments once per pulse; ext_trg_syn_out appears 3 clocks after each edge.
5. Preload eff_trg_cnt_out to 0xFFFF via 65535 accepts, then one more accept -> eff_trg_cnt_out=0x0000.
6. Stop pulse in RUN -> trg_enb_out=0 next clock, run_active_out=1 for DRAIN_CYCLES clocks, then IDLE. Start and stop together in IDLE -> stays IDLE. rst_in mid-RUN -> all outputs 0 the next clock.
